mc10_mode_latch_ext: RTL

- Parametrised successor to the single 6-bit VDG mode latch; sits on the CPU write strobe into the video/keyboard I/O region.
- Preserves the legacy behaviour: din[7:2] is latched as the VDG mode bits on ordinary writes.
- Adds a bank of extended mode registers (palette, border, extended graphics modes) reached through a two-byte unlock sequence, with single and burst (auto-increment) write modes.
- Signals extended-register updates to the clk_sys domain with a toggle handshake.

---
 rtl/mc10_pkg.sv | 23 ++
 rtl/mc10_toggle_sync.sv | 25 ++
 rtl/mc10_mode_latch_ext.sv | 116 +++++++++++
 3 files changed

// File: rtl/mc10_pkg.sv
// Shared definitions for the MC-10 mode latch slice.
//   - sequencer state encoding (matches the 2-bit state_q output)
//   - default unlock keys
//   - names of the extended register slots
package mc10_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_SEL  = 2'd2,
    ST_DATA = 2'd3
  } mc10_state_e;

  localparam logic [7:0] KEY0_DEF = 8'hA5;
  localparam logic [7:0] KEY1_DEF = 8'h5A;

  // Extended register slots, as used by software.
  localparam int EXT_PAL    = 0;
  localparam int EXT_BORDER = 1;
  localparam int EXT_GMX    = 2;
  localparam int EXT_CTRL   = 3;

endpackage

// File: rtl/mc10_toggle_sync.sv
// clk_sys-side receiver for the upd_tgl handshake of mc10_mode_latch_ext.
// Double-flops the toggle into clk_sys and emits a one-cycle pulse on
// every change. Instantiated by the consumer, not by the latch itself.
// Ports:
//   clk_sys    in  receiving clock
//   RESET      in  asynchronous, active-high reset
//   upd_tgl    in  toggle from the U8_clock domain
//   upd_pulse  out one clk_sys cycle high per extended-register write
module mc10_toggle_sync (
  input  logic clk_sys,
  input  logic RESET,
  input  logic upd_tgl,
  output logic upd_pulse
);

  logic [2:0] sync_r;  // [0],[1] synchroniser, [2] previous value for edge detect

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) sync_r <= '0;
    else       sync_r <= {sync_r[1:0], upd_tgl};
  end

  assign upd_pulse = sync_r[2] ^ sync_r[1];

endmodule

// File: rtl/mc10_mode_latch_ext.sv
// MC-10 VDG mode latch with an extended register bank.
// Ordinary writes latch din[7:8-LEGACY_W] as the legacy VDG mode bits.
// The sequence KEY0, KEY1, <index|burst>, <data>... writes the extended
// registers; bit 7 of the index byte selects auto-increment burst mode.
// Each extended write flips upd_tgl for the clk_sys-side receiver.
// Ports:
//   U8_clock  in  one rising edge per CPU write to the latch address
//   RESET     in  asynchronous, active-high reset
//   din       in  CPU data bus at the write strobe
//   legacy_q  out legacy VDG mode bits
//   ext_q     out flattened extended registers, reg i at [i*EXT_W +: EXT_W]
//   ext_idx   out extended register pointer
//   state_q   out sequencer state (IDLE/ARM/SEL/DATA)
//   burst_q   out burst mode active
//   upd_tgl   out toggles once per extended-register write
module mc10_mode_latch_ext
  import mc10_pkg::*;
#(
  parameter int          LEGACY_W = 6,
  parameter int          EXT_REGS = 4,
  parameter int          EXT_W    = 8,
  parameter logic [7:0]  KEY0     = KEY0_DEF,
  parameter logic [7:0]  KEY1     = KEY1_DEF,
  localparam int         IDX_W    = (EXT_REGS > 1) ? $clog2(EXT_REGS) : 1
) (
  input  logic                      U8_clock,
  input  logic                      RESET,
  input  logic [7:0]                din,
  output logic [LEGACY_W-1:0]       legacy_q,
  output logic [EXT_REGS*EXT_W-1:0] ext_q,
  output logic [IDX_W-1:0]          ext_idx,
  output logic [1:0]                state_q,
  output logic                      burst_q,
  output logic                      upd_tgl
);

  // One extra bit so EXT_REGS itself fits for the range check.
  localparam logic [IDX_W:0]   NREG = (IDX_W+1)'(EXT_REGS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(EXT_REGS - 1);

  mc10_state_e state, state_nx;

  logic [EXT_REGS-1:0][EXT_W-1:0] ext_r;
  logic [IDX_W-1:0]               sel_idx;
  logic                           sel_ok;
  logic                           burst_more;
  logic                           lat_leg, ld_sel, wr_ext;

  assign sel_idx    = din[IDX_W-1:0];
  assign sel_ok     = {1'b0, sel_idx} < NREG;
  // Burst never wraps: the last register always closes the sequence.
  assign burst_more = burst_q && (ext_idx < LAST);

  // State register
  always_ff @(posedge U8_clock or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = (din == KEY0) ? ST_ARM : ST_IDLE;
      ST_ARM: begin
        if      (din == KEY1) state_nx = ST_SEL;
        else if (din == KEY0) state_nx = ST_ARM;
        else                  state_nx = ST_IDLE;
      end
      ST_SEL:  state_nx = sel_ok ? ST_DATA : ST_IDLE;
      ST_DATA: state_nx = burst_more ? ST_DATA : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Per-state datapath controls. Key bytes reach the legacy latch too;
  // software rewrites the mode after an unlock sequence.
  always_comb begin
    lat_leg = 1'b0;
    ld_sel  = 1'b0;
    wr_ext  = 1'b0;
    case (state)
      ST_IDLE, ST_ARM: lat_leg = 1'b1;
      ST_SEL:          ld_sel  = 1'b1;
      ST_DATA:         wr_ext  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge U8_clock or posedge RESET) begin
    if (RESET) begin
      legacy_q <= '0;
      ext_r    <= '0;
      ext_idx  <= '0;
      burst_q  <= 1'b0;
      upd_tgl  <= 1'b0;
    end else begin
      if (lat_leg) legacy_q <= din[7 -: LEGACY_W];
      if (ld_sel) begin
        ext_idx <= sel_idx;
        burst_q <= din[7] & sel_ok;  // an invalid index drops burst
      end
      if (wr_ext) begin
        for (int i = 0; i < EXT_REGS; i++)
          if (ext_idx == IDX_W'(i)) ext_r[i] <= din[EXT_W-1:0];
        upd_tgl <= ~upd_tgl;
        if (burst_more) ext_idx <= ext_idx + 1'b1;
        else            burst_q <= 1'b0;  // ext_idx keeps its last value
      end
    end
  end

  assign ext_q   = ext_r;
  assign state_q = state;

endmodule
